// File: rtl/core_sequencer.sv
// Multi-cycle control FSM: steps each instruction through fetch, decode, execute,
// memory and writeback, and decides the cycle in which each strobe takes effect.
module core_sequencer #(
    parameter int MEMORY_TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_COUNTER_WIDTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  opcode,
    input  logic        branch_taken,
    input  logic        memory_ready,
    output logic        memory_request_valid,
    output logic        memory_address_select,
    output logic        memory_write_enable,
    output logic        instruction_register_load,
    output logic        register_write_enable,
    output logic [2:0]  writeback_select,
    output logic        pc_write_enable,
    output logic [1:0]  pc_source,
    output logic        halted,
    output logic [1:0]  halt_cause,
    output logic [31:0] retired_count,
    output logic [2:0]  state
);

    localparam logic [2:0] FETCH     = 3'd0;
    localparam logic [2:0] DECODE    = 3'd1;
    localparam logic [2:0] EXECUTE   = 3'd2;
    localparam logic [2:0] MEMORY    = 3'd3;
    localparam logic [2:0] WRITEBACK = 3'd4;
    localparam logic [2:0] HALT      = 3'd5;

    localparam logic [4:0] OP_REG    = 5'b01100;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    localparam logic [1:0] CAUSE_SYSTEM  = 2'd1;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    localparam int NUM_LEGAL = 10;
    localparam logic [NUM_LEGAL*5-1:0] LEGAL_OPS = {
        OP_REG, OP_IMM, OP_BRANCH, OP_JAL, OP_JALR,
        OP_AUIPC, OP_LUI, OP_LOAD, OP_STORE, OP_SYSTEM
    };

    // The wait that would bring the counter up to the limit is the last one allowed.
    localparam logic [TIMEOUT_COUNTER_WIDTH-1:0] TIMEOUT_LAST =
        TIMEOUT_COUNTER_WIDTH'(MEMORY_TIMEOUT_CYCLES - 1);

    logic [2:0]                       state_reg, state_next;
    logic [4:0]                       op_class_reg, op_class_next;
    logic [TIMEOUT_COUNTER_WIDTH-1:0] wait_count_reg, wait_count_next;
    logic                             halted_reg, halted_next;
    logic [1:0]                       halt_cause_reg, halt_cause_next;
    logic [31:0]                      retired_count_reg, retired_count_next;

    logic [NUM_LEGAL-1:0] legal_hit;
    logic                 opcode_legal;
    logic                 class_is_load;
    logic                 class_is_store;
    logic                 timeout_hit;

    logic       req_valid_s;
    logic       addr_sel_s;
    logic       mem_we_s;
    logic       ir_load_s;
    logic       rd_we_s;
    logic [2:0] wb_sel_s;
    logic       pc_we_s;
    logic [1:0] pc_src_s;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEGAL; gi++) begin : g_legal
            assign legal_hit[gi] = (opcode == LEGAL_OPS[gi*5 +: 5]);
        end
    endgenerate

    assign opcode_legal   = |legal_hit;
    assign class_is_load  = (op_class_reg == OP_LOAD);
    assign class_is_store = (op_class_reg == OP_STORE);
    assign timeout_hit    = (wait_count_reg == TIMEOUT_LAST);

    // Strobe decode: Moore on state and latched class, qualified by memory_ready
    // only where a handshake completes.
    always_comb begin
        req_valid_s = 1'b0;
        addr_sel_s  = 1'b0;
        mem_we_s    = 1'b0;
        ir_load_s   = 1'b0;
        rd_we_s     = 1'b0;
        wb_sel_s    = 3'd0;
        pc_we_s     = 1'b0;
        pc_src_s    = 2'd0;
        case (state_reg)
            FETCH: begin
                req_valid_s = 1'b1;
                ir_load_s   = memory_ready;
            end
            MEMORY: begin
                req_valid_s = 1'b1;
                addr_sel_s  = 1'b1;
                mem_we_s    = class_is_store;
                pc_we_s     = class_is_store & memory_ready;
            end
            WRITEBACK: begin
                pc_we_s = 1'b1;
                case (op_class_reg)
                    OP_REG, OP_IMM: begin
                        rd_we_s = 1'b1;
                    end
                    OP_LOAD: begin
                        rd_we_s  = 1'b1;
                        wb_sel_s = 3'd1;
                    end
                    OP_JAL: begin
                        rd_we_s  = 1'b1;
                        wb_sel_s = 3'd2;
                        pc_src_s = 2'd1;
                    end
                    OP_JALR: begin
                        rd_we_s  = 1'b1;
                        wb_sel_s = 3'd2;
                        pc_src_s = 2'd2;
                    end
                    OP_AUIPC: begin
                        rd_we_s  = 1'b1;
                        wb_sel_s = 3'd3;
                    end
                    OP_LUI: begin
                        rd_we_s  = 1'b1;
                        wb_sel_s = 3'd4;
                    end
                    OP_BRANCH: begin
                        pc_src_s = branch_taken ? 2'd1 : 2'd0;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        op_class_next   = op_class_reg;
        halted_next     = halted_reg;
        halt_cause_next = halt_cause_reg;
        case (state_reg)
            FETCH: begin
                if (memory_ready) begin
                    state_next = DECODE;
                end else if (timeout_hit) begin
                    state_next      = HALT;
                    halted_next     = 1'b1;
                    halt_cause_next = CAUSE_TIMEOUT;
                end
            end
            DECODE: begin
                op_class_next = opcode;
                if (opcode == OP_SYSTEM) begin
                    state_next      = HALT;
                    halted_next     = 1'b1;
                    halt_cause_next = CAUSE_SYSTEM;
                end else if (!opcode_legal) begin
                    state_next      = HALT;
                    halted_next     = 1'b1;
                    halt_cause_next = CAUSE_ILLEGAL;
                end else begin
                    state_next = EXECUTE;
                end
            end
            EXECUTE: begin
                state_next = (class_is_load || class_is_store) ? MEMORY : WRITEBACK;
            end
            MEMORY: begin
                if (memory_ready) begin
                    state_next = class_is_load ? WRITEBACK : FETCH;
                end else if (timeout_hit) begin
                    state_next      = HALT;
                    halted_next     = 1'b1;
                    halt_cause_next = CAUSE_TIMEOUT;
                end
            end
            WRITEBACK: begin
                state_next = FETCH;
            end
            HALT: ;
            default: begin
                state_next      = HALT;
                halted_next     = 1'b1;
                halt_cause_next = CAUSE_ILLEGAL;
            end
        endcase
    end

    // Any state change restarts the wait window, so FETCH and MEMORY always start at 0.
    always_comb begin
        wait_count_next = wait_count_reg;
        if (state_next != state_reg) begin
            wait_count_next = '0;
        end else if (req_valid_s && !memory_ready) begin
            wait_count_next = wait_count_reg + 1'b1;
        end
    end

    assign retired_count_next = retired_count_reg + {31'd0, pc_we_s};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg         <= FETCH;
            op_class_reg      <= 5'd0;
            wait_count_reg    <= '0;
            halted_reg        <= 1'b0;
            halt_cause_reg    <= 2'd0;
            retired_count_reg <= 32'd0;
        end else begin
            state_reg         <= state_next;
            op_class_reg      <= op_class_next;
            wait_count_reg    <= wait_count_next;
            halted_reg        <= halted_next;
            halt_cause_reg    <= halt_cause_next;
            retired_count_reg <= retired_count_next;
        end
    end

    assign memory_request_valid      = req_valid_s & ~reset;
    assign memory_address_select     = addr_sel_s & ~reset;
    assign memory_write_enable       = mem_we_s & ~reset;
    assign instruction_register_load = ir_load_s & ~reset;
    assign register_write_enable     = rd_we_s & ~reset;
    assign writeback_select          = wb_sel_s & {3{~reset}};
    assign pc_write_enable           = pc_we_s & ~reset;
    assign pc_source                 = pc_src_s & {2{~reset}};
    assign halted                    = halted_reg;
    assign halt_cause                = halt_cause_reg;
    assign retired_count             = retired_count_reg;
    assign state                     = state_reg;

endmodule
